// File: rtl/ahb2apb_pkg.sv
// Shared encodings for the AHB-Lite to APB bridge.
package ahb2apb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LATCH  = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERR1   = 3'd5;
    localparam logic [2:0] ST_ERR2   = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LATCH  = ST_LATCH,
        S_SETUP  = ST_SETUP,
        S_ACCESS = ST_ACCESS,
        S_DONE   = ST_DONE,
        S_ERR1   = ST_ERR1,
        S_ERR2   = ST_ERR2
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [1:0] HRESP_OKAY  = 2'd0;
    localparam logic [1:0] HRESP_ERROR = 2'd1;

endpackage

// File: rtl/ahb2apb_if.sv
// AHB-Lite slave side and APB master side of the bridge.
interface ahb2apb_if #(
    parameter int NUM_SLV = 4
);
    logic                   HSEL;
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [2:0]             HSIZE;
    logic [31:0]            HWDATA;
    logic                   HREADY;
    logic                   HREADYOUT;
    logic [31:0]            HRDATA;
    logic [1:0]             HRESP;
    logic [31:0]            PADDR;
    logic [NUM_SLV-1:0]     PSEL;
    logic                   PENABLE;
    logic                   PWRITE;
    logic [31:0]            PWDATA;
    logic [NUM_SLV*32-1:0]  PRDATA_BUS;

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  PRDATA_BUS,
        output HREADYOUT, HRDATA, HRESP,
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output PRDATA_BUS,
        input  HREADYOUT, HRDATA, HRESP,
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/ahb2apb_dec.sv
// Slave index decode: one-hot select, range flag, read-data mux.
module ahb2apb_dec #(
    parameter int NUM_SLV   = 4,
    parameter int SLV_IDX_W = 4
) (
    input  logic [SLV_IDX_W-1:0]   idx,
    input  logic [NUM_SLV*32-1:0]  prdata_bus,
    output logic [NUM_SLV-1:0]     sel,
    output logic                   in_range,
    output logic [31:0]            prdata
);

    always_comb begin
        sel      = '0;
        in_range = 1'b0;
        prdata   = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx == SLV_IDX_W'(i)) begin
                sel[i]   = 1'b1;
                in_range = 1'b1;
                prdata   = prdata_bus[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge; one SETUP+ACCESS per transfer.
module ahb2apb_bridge
    import ahb2apb_pkg::*;
#(
    parameter int NUM_SLV   = 4,
    parameter int SLV_LSB   = 12,
    parameter int SLV_IDX_W = 4
) (
    input  logic     PCLK,
    input  logic     PRST_N,
    ahb2apb_if.slave bus
);

    state_t                state;
    logic [31:0]           addr_q;
    logic                  write_q;
    logic [SLV_IDX_W-1:0]  idx_q;

    logic                  hready_q;
    logic [1:0]            hresp_q;
    logic [31:0]           hrdata_q;
    logic [31:0]           paddr_q;
    logic [NUM_SLV-1:0]    psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [31:0]           pwdata_q;

    logic [SLV_IDX_W-1:0]  hidx;
    logic [SLV_IDX_W-1:0]  dec_idx;
    logic [NUM_SLV-1:0]    sel;
    logic                  in_range;
    logic [31:0]           prdata;
    logic                  accept;
    logic                  can_accept;
    logic                  unused_hsize;

    assign hidx   = bus.HADDR[SLV_LSB +: SLV_IDX_W];
    assign accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign unused_hsize = ^bus.HSIZE;

    // Decode the live address while idle, the held index once in flight.
    assign can_accept = (state == S_IDLE) || (state == S_DONE) ||
                        (state == S_ERR2);
    assign dec_idx    = can_accept ? hidx : idx_q;

    ahb2apb_dec #(
        .NUM_SLV   (NUM_SLV),
        .SLV_IDX_W (SLV_IDX_W)
    ) u_dec (
        .idx        (dec_idx),
        .prdata_bus (bus.PRDATA_BUS),
        .sel        (sel),
        .in_range   (in_range),
        .prdata     (prdata)
    );

    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            state     <= S_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            hready_q  <= 1'b1;
            hresp_q   <= HRESP_OKAY;
            hrdata_q  <= '0;
            paddr_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_ERR2: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    if (accept) begin
                        addr_q   <= bus.HADDR;
                        write_q  <= bus.HWRITE;
                        idx_q    <= hidx;
                        hready_q <= 1'b0;
                        if (in_range) begin
                            state   <= S_LATCH;
                            hresp_q <= HRESP_OKAY;
                        end else begin
                            state   <= S_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end
                    end else begin
                        state    <= S_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                S_LATCH: begin
                    if (write_q) pwdata_q <= bus.HWDATA;
                    paddr_q  <= addr_q;
                    pwrite_q <= write_q;
                    psel_q   <= sel;
                    state    <= S_SETUP;
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state     <= S_ACCESS;
                end
                S_ACCESS: begin
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    hready_q  <= 1'b1;
                    if (!write_q) hrdata_q <= prdata;
                    state     <= S_DONE;
                end
                S_ERR1: begin
                    hready_q <= 1'b1;
                    state    <= S_ERR2;
                end
                default: begin
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.HREADYOUT = hready_q;
    assign bus.HRESP     = hresp_q;
    assign bus.HRDATA    = hrdata_q;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Directed bench for ahb2apb_bridge with a transfer-timeline reference model.
module tb_ahb2apb_bridge;

    localparam int NS = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    ahb2apb_if #(.NUM_SLV(NS)) bus();

    ahb2apb_bridge #(
        .NUM_SLV   (NS),
        .SLV_LSB   (12),
        .SLV_IDX_W (4)
    ) dut (
        .PCLK   (clk),
        .PRST_N (rst_n),
        .bus    (bus)
    );

    logic [31:0] slv_rd [NS];
    assign bus.PRDATA_BUS = {slv_rd[3], slv_rd[2], slv_rd[1], slv_rd[0]};
    assign bus.HREADY     = bus.HREADYOUT;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a transfer is a timeline of cycles after accept.
    bit          m_active;
    bit          m_err;
    bit          m_write;
    int          m_k;
    int          m_idx;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_hrdata;

    int          cyc;
    int          low_cnt;
    int          err_cnt;
    bit          err_rdy [$];
    int          setup_cyc [$];
    int          access_cyc [$];
    logic [31:0] acc_pwdata [$];
    logic [3:0]  last_psel;
    logic [31:0] last_paddr;

    task automatic clr_mon();
        low_cnt = 0;
        err_cnt = 0;
        err_rdy.delete();
        setup_cyc.delete();
        access_cyc.delete();
        acc_pwdata.delete();
        last_psel  = '0;
        last_paddr = '0;
    endtask

    always @(posedge clk) begin
        bit ready;
        bit apb;
        if (!rst_n) begin
            m_active = 0;
            m_k      = 0;
            m_hrdata = '0;
        end else begin
            ready = !m_active || (m_err ? m_k == 2 : m_k == 4);
            if (ready && bus.HSEL && bus.HREADY && bus.HTRANS[1]) begin
                m_active = 1;
                m_k      = 1;
                m_addr   = bus.HADDR;
                m_write  = bus.HWRITE;
                m_idx    = int'(bus.HADDR[15:12]);
                m_err    = m_idx >= NS;
            end else if (m_active) begin
                if (ready) begin
                    m_active = 0;
                end else begin
                    if (!m_err && m_k == 1 && m_write) m_wdata = bus.HWDATA;
                    if (!m_err && m_k == 3 && !m_write)
                        m_hrdata = slv_rd[m_idx];
                    m_k++;
                end
            end
        end
        #1;
        ready = !m_active || (m_err ? m_k == 2 : m_k == 4);
        apb   = m_active && !m_err && (m_k == 2 || m_k == 3);
        chk("hreadyout", 32'(bus.HREADYOUT), 32'(ready));
        chk("hresp", 32'(bus.HRESP), (m_active && m_err) ? 32'd1 : 32'd0);
        chk("psel", 32'(bus.PSEL), apb ? (32'd1 << m_idx) : 32'd0);
        chk("penable", 32'(bus.PENABLE), 32'(apb && m_k == 3));
        chk("hrdata", bus.HRDATA, m_hrdata);
        if (apb) begin
            chk("paddr", bus.PADDR, m_addr);
            chk("pwrite", 32'(bus.PWRITE), 32'(m_write));
            if (m_write) chk("pwdata", bus.PWDATA, m_wdata);
        end
        cyc++;
        if (!bus.HREADYOUT) low_cnt++;
        if (bus.HRESP == 2'd1) begin
            err_cnt++;
            err_rdy.push_back(bus.HREADYOUT);
        end
        if (bus.PSEL != 0 && !bus.PENABLE) setup_cyc.push_back(cyc);
        if (bus.PSEL != 0 && bus.PENABLE) begin
            access_cyc.push_back(cyc);
            acc_pwdata.push_back(bus.PWDATA);
            last_psel  = bus.PSEL;
            last_paddr = bus.PADDR;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [1:0]  trans;
    } item_t;

    item_t seq [$];

    task automatic drive_idle();
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'd0;
        bus.HWRITE = 1'b0;
        bus.HADDR  = '0;
    endtask

    // Issues each address phase whenever the bus is ready (pipelined).
    task automatic run_seq();
        int i = 0;
        int last_j = -1;
        int guard = 0;
        while (1) begin
            @(negedge clk);
            guard++;
            if (guard > 60) begin
                checks++;
                errors++;
                $display("FAIL run_seq: timeout got %0d cycles expected <= 60",
                         guard);
                break;
            end
            if (last_j >= 0) begin
                bus.HWDATA = seq[last_j].wdata;
                last_j = -1;
            end
            if (bus.HREADYOUT) begin
                if (i < seq.size()) begin
                    bus.HSEL   = 1'b1;
                    bus.HADDR  = seq[i].addr;
                    bus.HWRITE = seq[i].write;
                    bus.HTRANS = seq[i].trans;
                    last_j = i;
                    i++;
                end else begin
                    drive_idle();
                    break;
                end
            end
        end
        @(posedge clk);
        #2;
        seq.delete();
    endtask

    function automatic item_t mk(input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic [1:0] t);
        item_t it;
        it.addr  = a;
        it.write = w;
        it.wdata = d;
        it.trans = t;
        return it;
    endfunction

    initial begin
        #100000;
        $display("FAIL global_timeout: got 100000ns expected finish earlier");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b0;
        bus.HSIZE  = 3'b010;
        bus.HWDATA = '0;
        drive_idle();
        slv_rd[0] = 32'h0BAD_0000;
        slv_rd[1] = 32'h0BAD_0001;
        slv_rd[2] = 32'h1234_5678;
        slv_rd[3] = 32'hCAFE_0003;
        cyc = 0;
        clr_mon();

        repeat (2) @(negedge clk);
        chk("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("rst_psel", 32'(bus.PSEL), 32'd0);
        chk("rst_paddr", bus.PADDR, 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single write to slave 1
        clr_mon();
        seq.push_back(mk(32'h0000_1018, 1'b1, 32'hA5A5_0F0F, 2'd2));
        run_seq();
        chk("wr_low_cycles", 32'(low_cnt), 32'd3);
        chk("wr_setup_cnt", 32'(setup_cyc.size()), 32'd1);
        chk("wr_access_cnt", 32'(access_cyc.size()), 32'd1);
        if (setup_cyc.size() == 1 && access_cyc.size() == 1) begin
            chk("wr_setup_to_access", 32'(access_cyc[0] - setup_cyc[0]), 32'd1);
            chk("wr_pwdata", acc_pwdata[0], 32'hA5A5_0F0F);
        end
        chk("wr_psel", 32'(last_psel), 32'h2);
        chk("wr_paddr", last_paddr, 32'h0000_1018);

        // Single read from slave 2
        clr_mon();
        seq.push_back(mk(32'h0000_2018, 1'b0, 32'h0, 2'd2));
        run_seq();
        chk("rd_hrdata", bus.HRDATA, 32'h1234_5678);
        chk("rd_hresp", 32'(bus.HRESP), 32'd0);
        chk("rd_psel", 32'(last_psel), 32'h4);

        // Out-of-range slave index 5
        clr_mon();
        seq.push_back(mk(32'h0000_5000, 1'b0, 32'h0, 2'd2));
        run_seq();
        chk("oor_setup_cnt", 32'(setup_cyc.size()), 32'd0);
        chk("oor_err_cycles", 32'(err_cnt), 32'd2);
        if (err_rdy.size() == 2) begin
            chk("oor_rdy_first", 32'(err_rdy[0]), 32'd0);
            chk("oor_rdy_second", 32'(err_rdy[1]), 32'd1);
        end
        chk("oor_hrdata_held", bus.HRDATA, 32'h1234_5678);

        // Back-to-back write then read, second issued in DONE
        clr_mon();
        seq.push_back(mk(32'h0000_101C, 1'b1, 32'h1111_2222, 2'd2));
        seq.push_back(mk(32'h0000_3000, 1'b0, 32'h0, 2'd2));
        run_seq();
        chk("b2b_access_cnt", 32'(access_cyc.size()), 32'd2);
        if (access_cyc.size() == 2 && setup_cyc.size() == 2) begin
            chk("b2b_gap", 32'(setup_cyc[1] - access_cyc[0]), 32'd3);
            chk("b2b_pwdata", acc_pwdata[0], 32'h1111_2222);
        end
        chk("b2b_hrdata", bus.HRDATA, 32'hCAFE_0003);
        chk("b2b_low_cycles", 32'(low_cnt), 32'd6);

        // IDLE and BUSY with HSEL high
        clr_mon();
        seq.push_back(mk(32'h0000_1000, 1'b1, 32'h0, 2'd0));
        seq.push_back(mk(32'h0000_2000, 1'b0, 32'h0, 2'd1));
        run_seq();
        chk("idle_low_cycles", 32'(low_cnt), 32'd0);
        chk("idle_setup_cnt", 32'(setup_cyc.size()), 32'd0);
        chk("idle_err_cycles", 32'(err_cnt), 32'd0);

        // Reset asserted during ACCESS of a read
        @(negedge clk);
        bus.HSEL   = 1'b1;
        bus.HADDR  = 32'h0000_2000;
        bus.HWRITE = 1'b0;
        bus.HTRANS = 2'd2;
        @(posedge clk);
        @(negedge clk);
        drive_idle();
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_penable", 32'(bus.PENABLE), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 32'(bus.PSEL), 32'd0);
        chk("arst_penable", 32'(bus.PENABLE), 32'd0);
        chk("arst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
        chk("arst_hrdata", bus.HRDATA, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
